// File: rtl/amux_pkg.sv
// Shared types and helpers for the break-before-make analog mux controller.
package amux_pkg;

    localparam int MAX_NCH = 16;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        DEAD = 2'd2
    } amux_state_t;

    // Returns a MAX_NCH-wide vector with only bit idx set; callers size-cast to NCH.
    function automatic logic [MAX_NCH-1:0] onehot(input int idx, input int nch);
        logic [MAX_NCH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            if ((i == idx) && (i < nch)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/amux_bbm_timer.sv
// Dead-time down-counter: start loads DEAD_CYC, done pulses during the last dead cycle.
module amux_bbm_timer #(
    parameter int DEAD_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    output logic done
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= 8'(DEAD_CYC);
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign done = (cnt == 8'd1);

endmodule

// File: rtl/amux_bbm_ctrl.sv
// Break-before-make analog mux channel controller.
// Optional macro AMUX_ERR_EN adds the err port that flags out-of-range requests.
module amux_bbm_ctrl
    import amux_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int SELW     = $clog2(NCH),
    parameter int DEAD_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SELW-1:0] sel_in,
    input  logic            sel_valid,
    output logic [NCH-1:0]  ch_en,
    output logic [SELW-1:0] sel_cur,
    output logic            busy
`ifdef AMUX_ERR_EN
    ,
    output logic            err
`endif
);

    amux_state_t     state, state_n;
    logic [SELW-1:0] pend, pend_n, sel_cur_n;
    logic [NCH-1:0]  ch_en_n;
    logic            rst_seen;
    logic            acc, in_range;
    logic            tmr_start, tmr_clr, tmr_done;

    // rst_seen blocks acceptance on the first edge after reset release.
    assign in_range = (int'(sel_in) < NCH);
    assign acc      = sel_valid & en & ~busy & rst_seen;

    always_comb begin
        state_n   = state;
        sel_cur_n = sel_cur;
        pend_n    = pend;
        ch_en_n   = '0;
        tmr_start = 1'b0;
        tmr_clr   = 1'b0;
        if (!en) begin
            state_n = OFF;
            tmr_clr = 1'b1;
        end else begin
            case (state)
                OFF: begin
                    if (acc && in_range) begin
                        state_n   = ON;
                        sel_cur_n = sel_in;
                        ch_en_n   = NCH'(onehot(int'(sel_in), NCH));
                    end
                end
                ON: begin
                    ch_en_n = NCH'(onehot(int'(sel_cur), NCH));
                    if (acc && in_range && (sel_in != sel_cur)) begin
                        state_n   = DEAD;
                        ch_en_n   = '0;
                        pend_n    = sel_in;
                        tmr_start = 1'b1;
                    end
                end
                DEAD: begin
                    if (tmr_done) begin
                        state_n   = ON;
                        sel_cur_n = pend;
                        ch_en_n   = NCH'(onehot(int'(pend), NCH));
                    end
                end
                default: begin
                    state_n = OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= OFF;
            ch_en    <= '0;
            sel_cur  <= '0;
            busy     <= 1'b0;
            rst_seen <= 1'b0;
        end else begin
            state    <= state_n;
            ch_en    <= ch_en_n;
            sel_cur  <= sel_cur_n;
            busy     <= (state_n == DEAD);
            rst_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pend <= pend_n;
    end

`ifdef AMUX_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= acc & ~in_range;
        end
    end
`endif

    amux_bbm_timer #(
        .DEAD_CYC(DEAD_CYC)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .start(tmr_start),
        .clr  (tmr_clr),
        .done (tmr_done)
    );

endmodule

// File: tb/tb_amux_bbm_ctrl.sv
// Directed bench for amux_bbm_ctrl: NCH=4 main instance plus an NCH=5 instance for out-of-range requests.
module tb_amux_bbm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_in = 2'd0;
    logic [3:0] ch_en;
    logic [1:0] sel_cur;
    logic       busy;

    logic       valid5 = 1'b0;
    logic [2:0] sel5 = 3'd0;
    logic [4:0] ch_en5;
    logic [2:0] sel_cur5;
    logic       busy5;
`ifdef AMUX_ERR_EN
    logic       err;
    logic       err5;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    amux_bbm_ctrl #(.NCH(4), .SELW(2), .DEAD_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sel_in(sel_in), .sel_valid(sel_valid),
        .ch_en(ch_en), .sel_cur(sel_cur), .busy(busy)
`ifdef AMUX_ERR_EN
        , .err(err)
`endif
    );

    amux_bbm_ctrl #(.NCH(5), .SELW(3), .DEAD_CYC(2)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .sel_in(sel5), .sel_valid(valid5),
        .ch_en(ch_en5), .sel_cur(sel_cur5), .busy(busy5)
`ifdef AMUX_ERR_EN
        , .err(err5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous one-hot/zero and no-direct-switch watch on both instances.
    logic [3:0] prev4 = '0;
    logic [4:0] prev5 = '0;
    always @(negedge clk) begin
        n_chk++;
        assert ($onehot0(ch_en) && !((prev4 != 0) && (ch_en != 0) && (ch_en != prev4))) else begin
            n_fail++;
            $error("FAIL onehot4 observed=%b expected one-hot/zero without direct switch from %b", ch_en, prev4);
        end
        n_chk++;
        assert ($onehot0(ch_en5) && !((prev5 != 0) && (ch_en5 != 0) && (ch_en5 != prev5))) else begin
            n_fail++;
            $error("FAIL onehot5 observed=%b expected one-hot/zero without direct switch from %b", ch_en5, prev5);
        end
        prev4 = ch_en;
        prev5 = ch_en5;
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_ch_en", 32'(ch_en), 32'h0);
        chk("rst_sel_cur", 32'(sel_cur), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef AMUX_ERR_EN
        chk("rst_err", 32'(err), 32'h0);
`endif
        en = 1'b1; sel_in = 2'd2; sel_valid = 1'b1;
        tick();
        chk("rst_hold_ch_en", 32'(ch_en), 32'h0);

        // Release: first edge only leaves reset, second edge accepts.
        rst = 1'b1;
        tick();
        chk("release_edge_ch_en", 32'(ch_en), 32'h0);
        tick();
        chk("first_ch_en", 32'(ch_en), 32'h4);
        chk("first_sel_cur", 32'(sel_cur), 32'h2);
        chk("first_busy", 32'(busy), 32'h0);
        sel_valid = 1'b0;
        tick();
        chk("hold_ch_en", 32'(ch_en), 32'h4);

        // Switch 2 -> 1 with a request for 3 while busy.
        sel_in = 2'd1; sel_valid = 1'b1;
        tick();
        chk("dead1_ch_en", 32'(ch_en), 32'h0);
        chk("dead1_busy", 32'(busy), 32'h1);
        sel_in = 2'd3;
        tick();
        chk("dead2_ch_en", 32'(ch_en), 32'h0);
        chk("dead2_busy", 32'(busy), 32'h1);
        tick();
        chk("sw_ch_en", 32'(ch_en), 32'h2);
        chk("sw_sel_cur", 32'(sel_cur), 32'h1);
        chk("sw_busy", 32'(busy), 32'h0);
        sel_valid = 1'b0;
        tick();
        chk("noqueue_ch_en", 32'(ch_en), 32'h2);

        // Same-channel request is ignored.
        sel_in = 2'd1; sel_valid = 1'b1;
        tick();
        chk("same_ch_en", 32'(ch_en), 32'h2);
        chk("same_busy", 32'(busy), 32'h0);
        sel_valid = 1'b0;

        // Drop en during the first dead cycle.
        sel_in = 2'd3; sel_valid = 1'b1;
        tick();
        chk("en_dead_busy", 32'(busy), 32'h1);
        sel_valid = 1'b0; en = 1'b0;
        tick();
        chk("en_off_ch_en", 32'(ch_en), 32'h0);
        chk("en_off_busy", 32'(busy), 32'h0);
        chk("en_off_sel_cur", 32'(sel_cur), 32'h1);
        en = 1'b1;
        tick();
        chk("en_back_ch_en", 32'(ch_en), 32'h0);
        sel_in = 2'd0; sel_valid = 1'b1;
        tick();
        chk("ch0_ch_en", 32'(ch_en), 32'h1);
        chk("ch0_sel_cur", 32'(sel_cur), 32'h0);
        sel_valid = 1'b0;

        // Move to channel 3, then reset asynchronously in the middle of DEAD.
        sel_in = 2'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        chk("ch3_ch_en", 32'(ch_en), 32'h8);
        chk("ch3_sel_cur", 32'(sel_cur), 32'h3);
        sel_in = 2'd1; sel_valid = 1'b1;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        sel_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_sel_cur", 32'(sel_cur), 32'h0);
        chk("async_ch_en", 32'(ch_en), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        sel_in = 2'd1; sel_valid = 1'b1;
        tick();
        chk("post_rst_ch_en", 32'(ch_en), 32'h2);
        chk("post_rst_busy", 32'(busy), 32'h0);
        sel_valid = 1'b0;

        // NCH=5 instance: valid channel 4, then out-of-range 6.
        sel5 = 3'd4; valid5 = 1'b1;
        tick();
        chk("n5_ch_en", 32'(ch_en5), 32'h10);
        chk("n5_sel_cur", 32'(sel_cur5), 32'h4);
        sel5 = 3'd6;
        tick();
        chk("oor_ch_en", 32'(ch_en5), 32'h10);
        chk("oor_sel_cur", 32'(sel_cur5), 32'h4);
        chk("oor_busy", 32'(busy5), 32'h0);
`ifdef AMUX_ERR_EN
        chk("oor_err", 32'(err5), 32'h1);
`endif
        valid5 = 1'b0;
        tick();
        chk("oor_after_ch_en", 32'(ch_en5), 32'h10);
`ifdef AMUX_ERR_EN
        chk("oor_err_clear", 32'(err5), 32'h0);
`endif

        // en falling together with a request: en wins.
        en = 1'b0; sel_in = 2'd3; sel_valid = 1'b1;
        tick();
        chk("enprio_ch_en", 32'(ch_en), 32'h0);
        chk("enprio_busy", 32'(busy), 32'h0);
        en = 1'b1; sel_valid = 1'b0;
        tick();
        chk("enprio_off_ch_en", 32'(ch_en), 32'h0);
        sel_in = 2'd2; sel_valid = 1'b1;
        tick();
        chk("final_ch_en", 32'(ch_en), 32'h4);
        sel_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("final_async_ch_en", 32'(ch_en), 32'h0);
        chk("final_async_sel_cur", 32'(sel_cur), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/amux_bbm_ctrl.md
AMUX_BBM_CTRL -- requirements
Module: amux_bbm_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of analog mux channels, range 2..16.
REQ-002 Parameter SELW, default $clog2(NCH): width of the channel select code.
REQ-003 Parameter DEAD_CYC, default 2: break-before-make dead time in clk cycles, range 1..255.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 en  input  1: global enable; low forces all channels off.
REQ-007 sel_in  input  SELW: requested channel index.
REQ-008 sel_valid  input  1: request strobe; a request is accepted on a rising edge where sel_valid=1, busy=0 and en=1.
REQ-009 ch_en  output  NCH: registered one-hot (or all-zero) channel switch enables.
REQ-010 sel_cur  output  SELW: index of the last channel made active.
REQ-011 busy  output  1: high while a break-before-make sequence is in progress.
REQ-012 err  output  1: one-cycle pulse on a rejected out-of-range request; present only with AMUX_ERR_EN.

Function
REQ-013 The FSM shall have exactly three states:
- OFF: ch_en=0.
- ON: ch_en=onehot(sel_cur).
- DEAD: ch_en=0, counting.
REQ-014 In OFF, an accepted request shall load sel_cur and enter ON at the same edge, so ch_en=onehot(sel_in) from the next cycle (1-cycle latency).
REQ-015 In ON, an accepted request with sel_in equal to sel_cur shall be ignored: no state change, no dead time.
REQ-016 In ON, an accepted request with sel_in different from sel_cur shall, at the same edge:
- clear ch_en;
- enter DEAD;
- set busy;
- capture sel_in into a pending register.
REQ-017 ch_en shall be all-zero for exactly DEAD_CYC cycles. At the edge ending the count:
- ch_en=onehot(pending);
- sel_cur=pending;
- busy clears;
- state returns to ON.
REQ-018 sel_valid while busy=1 shall be ignored; no queueing.
REQ-019 en=0 shall move any state to OFF at the next edge:
- ch_en=0;
- busy=0;
- any dead-time count and pending request discarded;
- sel_cur retained.
REQ-020 If en falls in the same cycle as a request, en has priority and the request is not accepted.
REQ-021 ch_en shall never have more than one bit set in any cycle, and shall never switch directly from one non-zero value to a different non-zero value.
REQ-022 A request with sel_in >= NCH (possible only when NCH is not a power of two) shall never be accepted.

Reset
REQ-023 While rst=0, regardless of clk:
- state=OFF;
- ch_en=0;
- sel_cur=0;
- busy=0;
- err=0;
- dead-time counter=0.
REQ-024 Reset asserted mid-DEAD shall abandon the sequence, and the first accepted request after release shall follow REQ-014.
REQ-025 Reset deassertion shall take effect at the first clk edge after rst rises, with no request accepted on that edge.

Configuration
REQ-026 Macro AMUX_ERR_EN defined:
- err port exists;
- an out-of-range request that is otherwise acceptable (busy=0, en=1) pulses err high for exactly one cycle;
- state is unchanged by that request.
REQ-027 Macro AMUX_ERR_EN undefined:
- err port and its logic are absent;
- out-of-range requests are silently dropped.

Structure
REQ-028 Package amux_pkg shall hold the FSM state enum (OFF/ON/DEAD) and a onehot-decode function parameterised by NCH.
REQ-029 The dead-time counter shall be a sub-module amux_bbm_timer with ports:
- clk, rst;
- start: load DEAD_CYC;
- clr: abandon the count;
- done: single-cycle pulse on expiry.
REQ-030 All outputs shall be driven directly from flops; no combinational path from inputs to ch_en.

Verification (NCH=4, DEAD_CYC=2 unless stated)
REQ-031 Release reset, en=1, request sel_in=2 -> ch_en=4'b0100 one cycle later; busy stays 0; sel_cur=2.
REQ-032 From channel 2, request sel_in=1 -> ch_en=0 for exactly 2 cycles, busy=1 for those 2 cycles, then ch_en=4'b0010 and sel_cur=1.
REQ-033 From channel 1, request sel_in=1 -> ch_en stays 4'b0010 and busy stays 0; a request sel_in=3 made while busy=1 -> ignored.
REQ-034 Drop en in the first DEAD cycle -> next cycle ch_en=0 and busy=0; en=1 with request sel_in=0 -> ch_en=4'b0001 after 1 cycle.
REQ-035 NCH=5 with AMUX_ERR_EN defined, request sel_in=6 -> one-cycle err pulse and ch_en unchanged; with the macro undefined, the same request leaves ch_en unchanged.
REQ-036 Assert rst mid-DEAD -> all outputs 0 immediately, asynchronously; a one-hot/zero assertion on ch_en holds across all scenarios.
